// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB PWM fader.
// Contents: fade FSM state enum, cfg_chan channel encodings, default level width.
package rgb_pwm_pkg;

  // Default width of the brightness level and of the PWM period counter
  localparam int PWM_BITS_DEF = 8;

  // cfg_chan encodings
  localparam logic [1:0] CH_R   = 2'd0;
  localparam logic [1:0] CH_G   = 2'd1;
  localparam logic [1:0] CH_B   = 2'd2;
  localparam logic [1:0] CH_ALL = 2'd3;

  // IDLE: every level equals its target; RAMP: at least one channel still fading
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } fade_state_t;

endpackage

// File: rtl/rgb_pwm_chan.sv
// One colour channel of the fader: target register, level that walks one LSB per
// step tick toward the target, compare shadow reloaded only at the end of a PWM
// period, and the registered PWM comparator.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   wr_en         - load wr_level into the target register this edge
//   wr_level      - new target brightness
//   step_tick     - fade step strobe from the shared prescaler
//   period_end    - shared PWM counter is at its all-ones value
//   pwm_ctr       - shared free-running PWM counter
//   pwm           - registered PWM output, high while pwm_ctr < shadow
//   differs       - level has not yet reached target
module rgb_pwm_chan
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [PWM_BITS-1:0] wr_level,
  input  logic                step_tick,
  input  logic                period_end,
  input  logic [PWM_BITS-1:0] pwm_ctr,
  output logic                pwm,
  output logic                differs
);

  localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1'b1);

  logic [PWM_BITS-1:0] target_r;
  logic [PWM_BITS-1:0] level_r;
  logic [PWM_BITS-1:0] shadow_r;
  logic                pwm_r;

  // Target register; a tick on the same edge still sees the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      target_r <= LVL_ZERO;
    end else if (wr_en) begin
      target_r <= wr_level;
    end
  end

  // Level moves one LSB toward target per tick; the strict compares stop it at target
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= LVL_ZERO;
    end else if (step_tick && (level_r < target_r)) begin
      level_r <= level_r + LVL_ONE;
    end else if (step_tick && (level_r > target_r)) begin
      level_r <= level_r - LVL_ONE;
    end
  end

  // Shadow only changes as the counter wraps, so a period is never cut short
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= LVL_ZERO;
    end else if (period_end) begin
      shadow_r <= level_r;
    end
  end

  // Registered comparator: output trails pwm_ctr by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= (pwm_ctr < shadow_r);
    end
  end

  assign pwm     = pwm_r;
  assign differs = (target_r != level_r);

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED fader: three PWM channels whose brightness glides one LSB per fade step
// toward a target written over a valid/ready config port.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cfg_valid/cfg_ready - target write handshake (ready is low only during reset)
//   cfg_chan            - 0=red, 1=green, 2=blue, 3=all channels
//   cfg_level           - target brightness
//   pwm_r/pwm_g/pwm_b   - PWM drive to the LED driver
//   busy                - at least one channel is still fading
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int STEP_DIV = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_chan,
  input  logic [PWM_BITS-1:0] cfg_level,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b,
  output logic                busy
);

  localparam int                PRE_W    = $clog2(STEP_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1'b1);

  logic [PRE_W-1:0]    presc_r;
  logic [PWM_BITS-1:0] pwm_ctr_r;
  logic                tick_s;
  logic                period_end_s;
  logic                cfg_ready_s;
  logic                accept_s;
  logic [2:0]          wr_en_s;
  logic [2:0]          differs_s;
  logic                any_diff_s;
  fade_state_t         state_r;
  fade_state_t         state_nxt_s;
  logic                busy_s;

  // Ready depends only on reset, so a write held across reset lands on the first free edge
  assign cfg_ready_s  = ~rst;
  assign accept_s     = cfg_valid & cfg_ready_s;
  assign tick_s       = (presc_r == PRE_LAST);
  assign period_end_s = (pwm_ctr_r == {PWM_BITS{1'b1}});
  assign any_diff_s   = |differs_s;

  // Fade-step prescaler, 0..STEP_DIV-1; writes never restart it
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= PRE_ZERO;
    end else if (tick_s) begin
      presc_r <= PRE_ZERO;
    end else begin
      presc_r <= presc_r + PRE_ONE;
    end
  end

  // Free-running PWM period counter, wraps naturally at 2^PWM_BITS
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_ctr_r <= {PWM_BITS{1'b0}};
    end else begin
      pwm_ctr_r <= pwm_ctr_r + PWM_BITS'(1'b1);
    end
  end

  // Decode an accepted write into per-channel target load enables
  always_comb begin
    wr_en_s = 3'b000;
    if (accept_s) begin
      case (cfg_chan)
        CH_R:    wr_en_s = 3'b001;
        CH_G:    wr_en_s = 3'b010;
        CH_B:    wr_en_s = 3'b100;
        CH_ALL:  wr_en_s = 3'b111;
        default: wr_en_s = 3'b000;
      endcase
    end else begin
      wr_en_s = 3'b000;
    end
  end

  rgb_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_r (
    .clk(clk), .rst(rst), .wr_en(wr_en_s[0]), .wr_level(cfg_level),
    .step_tick(tick_s), .period_end(period_end_s), .pwm_ctr(pwm_ctr_r),
    .pwm(pwm_r), .differs(differs_s[0])
  );

  rgb_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_g (
    .clk(clk), .rst(rst), .wr_en(wr_en_s[1]), .wr_level(cfg_level),
    .step_tick(tick_s), .period_end(period_end_s), .pwm_ctr(pwm_ctr_r),
    .pwm(pwm_g), .differs(differs_s[1])
  );

  rgb_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_s[2]), .wr_level(cfg_level),
    .step_tick(tick_s), .period_end(period_end_s), .pwm_ctr(pwm_ctr_r),
    .pwm(pwm_b), .differs(differs_s[2])
  );

  // Fade FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: the FSM follows the registered target/level mismatch one edge later
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_diff_s) begin
          state_nxt_s = ST_RAMP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (any_diff_s) begin
          state_nxt_s = ST_RAMP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: busy is a pure function of the state register
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      ST_RAMP: busy_s = 1'b1;
      ST_IDLE: busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  assign busy      = busy_s;
  assign cfg_ready = cfg_ready_s;

endmodule

// File: doc/rgb_pwm_fader.md
RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, meaning width of the brightness level and of the PWM period counter.
REQ-002 SHALL have parameter STEP_DIV, default 1024, meaning clk cycles per fade step (legal range 2..65536).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port cfg_valid, input, 1 bit: a target-level write is offered.
REQ-006 SHALL have port cfg_ready, output, 1 bit: the block can accept a write.
REQ-007 SHALL have port cfg_chan, input, 2 bits: 0=red, 1=green, 2=blue, 3=all channels.
REQ-008 SHALL have port cfg_level, input, PWM_BITS: target brightness.
REQ-009 SHALL have ports pwm_r, pwm_g, pwm_b, output, 1 bit each: PWM drive into the RGB LED driver PWM inputs.
REQ-010 SHALL have port busy, output, 1 bit: at least one channel is still fading.

Function
REQ-011 Write accepted on any rising edge with cfg_valid=1 and cfg_ready=1; cfg_ready SHALL be 1 in every cycle except while rst=1.
REQ-012 An accepted write SHALL update the selected target register(s) on the same edge; cfg_chan=3 SHALL update all three channels.
REQ-013 The prescaler SHALL count 0..STEP_DIV-1 and wrap; the step tick is the cycle in which it equals STEP_DIV-1.
REQ-014 On a tick, each channel's level SHALL move one LSB toward its target: +1 if level<target, -1 if level>target, unchanged if equal.
REQ-015 A level SHALL never overshoot or wrap; levels are unsigned and saturate at target.
REQ-016 A target write that coincides with a tick SHALL have the tick compare against the old target; the new target applies from the next tick.
REQ-017 A target write during a fade SHALL continue the fade from the current level, with no jump and no restart of the prescaler.
REQ-018 The PWM counter SHALL be free-running, PWM_BITS wide, and wrap from 2^PWM_BITS-1 to 0.
REQ-019 Each channel SHALL hold a compare shadow that loads the channel level only in the cycle the PWM counter equals 2^PWM_BITS-1, making changes glitch-free and effective from the next period start.
REQ-020 pwm_x SHALL be registered, equal to (pwm_ctr < shadow_x), and 1 cycle late relative to pwm_ctr.
REQ-021 Duty SHALL be shadow/2^PWM_BITS: level 0 gives a constant 0, and level 255 (PWM_BITS=8) gives high 255 cycles out of 256.
REQ-022 Fade FSM states SHALL be IDLE (all levels equal targets) and RAMP (any level differs).
REQ-023 The FSM SHALL move IDLE->RAMP on the edge after an accepted write that makes any target differ from its level, and RAMP->IDLE on the edge after the tick that makes all levels equal.
REQ-024 busy SHALL be 1 exactly when the FSM is in RAMP.

Reset
REQ-025 While rst=1, all of the following SHALL be 0: targets, levels, shadows, prescaler, PWM counter, pwm_r/g/b, busy, cfg_ready; the FSM SHALL be in IDLE.
REQ-026 rst asserted mid-fade SHALL abandon the fade; cfg_valid SHALL be ignored while rst=1.
REQ-027 Counting SHALL resume from 0 on the first edge after rst deasserts.

Structure
REQ-028 Package rgb_pwm_pkg SHALL hold the fade state enum, the channel encodings (CH_R=0, CH_G=1, CH_B=2, CH_ALL=3), and the default PWM_BITS.
REQ-029 One sub-module, rgb_pwm_chan, SHALL hold the per-channel target/level/shadow/compare logic and be instantiated three times; the prescaler, PWM counter, FSM and cfg decode SHALL stay in the top level.
REQ-030 The implementation SHALL have no multipliers and no RAM, and SHALL be 120-400 lines of RTL.

Verification (STEP_DIV=4, PWM_BITS=8)
REQ-031 Reset, then 600 idle cycles -> pwm_r/g/b all 0, busy=0, cfg_ready=1 from the first cycle after rst drops.
REQ-032 Write chan=0 level=3 -> busy rises next edge; red level reaches 3 after exactly 3 ticks (12 cycles); busy falls the edge after; pwm_r then high 3 of every 256 cycles, pwm_g/pwm_b stay 0.
REQ-033 Write chan=3 level=255, wait for busy=0 -> each output is high 255 of 256 cycles; then write chan=1 level=0 -> green fades down 255 ticks to a constant 0.
REQ-034 Red ramping 0->200; at level 50 write red=20 -> level turns and decrements monotonically to 20 with no jump; a write landing on a tick edge is checked against REQ-016.
REQ-035 Change level mid PWM period -> pwm width changes only at the period following counter value 255; there is never a partial-period pulse.
REQ-036 Assert rst for 1 cycle mid-fade with cfg_valid held at 1 -> all state is 0 after reset; the write is ignored during rst and accepted on the first cycle after rst.
